// File: rtl/shift_sequencer.sv
//==============================================================================
// Module      : shift_sequencer
// Description : Controller for the one-step barrel shifter. It holds the
//               working word, debounces the push-buttons and runs an optional
//               auto-shift timer. Each shift step captures the shifter's
//               result and shifted-out bit back into the word.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module shift_sequencer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int AUTO_DIV        = 25000000   // must be >= 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_val,
    input  logic             btn_load,
    input  logic             btn_left,
    input  logic             btn_right,
    input  logic             mode_rotate,
    input  logic             fill_bit,
    input  logic             auto_en,
    output logic [WIDTH-1:0] sh_val,
    output logic             sh_dir,
    output logic             sh_in,
    input  logic [WIDTH-1:0] sh_res,
    input  logic             sh_out,
    output logic [WIDTH-1:0] led,
    output logic             carry,
    output logic [7:0]       shift_count,
    output logic             busy
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TICK_W = $clog2(AUTO_DIV + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_AUTO  = 2'd3
    } state_t;

    // Button index 0 = load, 1 = left, 2 = right.
    logic [2:0] w_btn_raw;
    logic [2:0] w_pulse;

    assign w_btn_raw = {btn_right, btn_left, btn_load};

    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic             sync1_q;
        logic             sync2_q;
        logic             level_q;
        logic             pulse_q;
        logic [CNT_W-1:0] cnt_q;

        // Synchronise, debounce, and emit a one-cycle pulse on an accepted press.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                level_q <= 1'b0;
                pulse_q <= 1'b0;
                cnt_q   <= '0;
            end else begin
                sync1_q <= w_btn_raw[gi];
                sync2_q <= sync1_q;
                pulse_q <= 1'b0;
                if (sync2_q != level_q) begin
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        level_q <= sync2_q;
                        cnt_q   <= '0;
                        pulse_q <= sync2_q;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign w_pulse[gi] = pulse_q;
    end

    logic w_p_load;
    logic w_p_left;
    logic w_p_right;

    assign w_p_load  = w_pulse[0];
    assign w_p_left  = w_pulse[1];
    assign w_p_right = w_pulse[2];

    logic auto_s1_q;
    logic auto_s2_q;

    // Two-flop synchroniser for the auto-shift enable switch.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            auto_s1_q <= 1'b0;
            auto_s2_q <= 1'b0;
        end else begin
            auto_s1_q <= auto_en;
            auto_s2_q <= auto_s1_q;
        end
    end

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    word_q, word_d;
    logic                dir_q, dir_d;
    logic                carry_q, carry_d;
    logic [7:0]          count_q, count_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [TICK_W-1:0]   w_tick_inc;

    assign w_tick_inc = tick_q + TICK_W'(1);

    // Sequencer state and working-word registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
            dir_q   <= 1'b1;
            carry_q <= 1'b0;
            count_q <= '0;
            tick_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            dir_q   <= dir_d;
            carry_q <= carry_d;
            count_q <= count_d;
            tick_q  <= tick_d;
        end
    end

    // Next-state logic; load beats left beats right, lower pulses are dropped.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        dir_d   = dir_q;
        carry_d = carry_q;
        count_d = count_q;
        tick_d  = tick_q;
        case (state_q)
            S_IDLE: begin
                if (w_p_load) begin
                    state_d = S_LOAD;
                end else if (w_p_left) begin
                    dir_d   = 1'b1;
                    state_d = S_SHIFT;
                end else if (w_p_right) begin
                    dir_d   = 1'b0;
                    state_d = S_SHIFT;
                end else if (auto_s2_q) begin
                    tick_d  = '0;
                    state_d = S_AUTO;
                end
            end
            S_LOAD: begin
                word_d  = sw_val;
                carry_d = 1'b0;
                count_d = '0;
                state_d = S_IDLE;
            end
            S_SHIFT: begin
                word_d  = sh_res;
                carry_d = sh_out;
                count_d = count_q + 8'd1;
                tick_d  = '0;
                state_d = auto_s2_q ? S_AUTO : S_IDLE;
            end
            default: begin // S_AUTO
                if (w_p_load) begin
                    state_d = S_LOAD;
                end else if (!auto_s2_q) begin
                    tick_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    // Direction buttons only steer the timer-driven steps.
                    if (w_p_left) begin
                        dir_d = 1'b1;
                    end else if (w_p_right) begin
                        dir_d = 1'b0;
                    end
                    if (w_tick_inc == TICK_W'(AUTO_DIV - 1)) begin
                        tick_d  = '0;
                        state_d = S_SHIFT;
                    end else begin
                        tick_d = w_tick_inc;
                    end
                end
            end
        endcase
    end

    // Rotate bit taken from the word itself so no loop forms through the shifter.
    assign sh_in       = mode_rotate ? (dir_q ? word_q[WIDTH-1] : word_q[0]) : fill_bit;
    assign sh_val      = word_q;
    assign sh_dir      = dir_q;
    assign led         = word_q;
    assign carry       = carry_q;
    assign shift_count = count_q;
    assign busy        = (state_q == S_LOAD) || (state_q == S_SHIFT);

endmodule

`default_nettype wire

// File: tb/tb_shift_sequencer.sv
//==============================================================================
// Module      : tb_shift_sequencer
// Description : Self-checking bench for shift_sequencer with a behavioural
//               one-step shifter and an arithmetic model of the working word.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_shift_sequencer;

    localparam int DB = 4;
    localparam int AD = 8;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] sw_val = '0;
    logic        btn_load = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        mode_rotate = 1'b0;
    logic        fill_bit = 1'b0;
    logic        auto_en = 1'b0;
    logic [15:0] sh_val;
    logic        sh_dir;
    logic        sh_in;
    logic [15:0] sh_res;
    logic        sh_out;
    logic [15:0] led;
    logic        carry;
    logic [7:0]  shift_count;
    logic        busy;

    shift_sequencer #(.WIDTH(16), .DEBOUNCE_CYCLES(DB), .AUTO_DIV(AD)) dut (
        .clock(clock), .reset_n(reset_n), .sw_val(sw_val),
        .btn_load(btn_load), .btn_left(btn_left), .btn_right(btn_right),
        .mode_rotate(mode_rotate), .fill_bit(fill_bit), .auto_en(auto_en),
        .sh_val(sh_val), .sh_dir(sh_dir), .sh_in(sh_in),
        .sh_res(sh_res), .sh_out(sh_out), .led(led), .carry(carry),
        .shift_count(shift_count), .busy(busy)
    );

    // Behavioural one-step barrel shifter.
    assign sh_res = sh_dir ? {sh_val[14:0], sh_in} : {sh_in, sh_val[15:1]};
    assign sh_out = sh_dir ? sh_val[15] : sh_val[0];

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Reference model of the visible state.
    int m_word = 0;
    int m_dir = 1;
    int m_carry = 0;
    int m_count = 0;

    function automatic int next_word(input int w, input int dir, input int rot, input int fill);
        int c;
        int b;
        c = dir ? (w / 32768) : (w % 2);
        b = rot ? c : fill;
        return dir ? ((w * 2) % 65536 + b) : (w / 2 + b * 32768);
    endfunction

    function automatic void model_step(input int dir, input int rot, input int fill);
        m_carry = dir ? (m_word / 32768) : (m_word % 2);
        m_word  = next_word(m_word, dir, rot, fill);
        m_count = (m_count + 1) % 256;
        m_dir   = dir;
    endfunction

    function automatic void model_load(input int v);
        m_word  = v;
        m_carry = 0;
        m_count = 0;
    endfunction

    // which: 0 load, 1 left, 2 right, 3 load+left together.
    task automatic press(input int which, input int hold, output int busy_n);
        busy_n = 0;
        @(negedge clock);
        case (which)
            0: btn_load = 1'b1;
            1: btn_left = 1'b1;
            2: btn_right = 1'b1;
            default: begin btn_load = 1'b1; btn_left = 1'b1; end
        endcase
        repeat (hold) begin
            @(negedge clock);
            if (busy) busy_n++;
        end
        btn_load = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
        repeat (14) begin
            @(negedge clock);
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        n_vec++; if (led !== 16'h0000) begin n_err++; $display("FAIL reset_led got=%h exp=0000", led); end
        n_vec++; if (sh_dir !== 1'b1) begin n_err++; $display("FAIL reset_dir got=%b exp=1", sh_dir); end
        n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got=%b exp=0", carry); end
        n_vec++; if (shift_count !== 8'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", shift_count); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
        reset_n = 1'b1;
        m_word = 0; m_dir = 1; m_carry = 0; m_count = 0;
        repeat (2) @(negedge clock);
    endtask

    task automatic test_load_fill();
        int b;
        sw_val = 16'h8001;
        press(0, 10, b);
        model_load(32'h8001);
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL load_led got=%h exp=%h", led, 16'(m_word)); end
        n_vec++; if (b != 1) begin n_err++; $display("FAIL load_busy_cycles got=%0d exp=1", b); end
        mode_rotate = 1'b0; fill_bit = 1'b0;
        press(1, 10, b);
        model_step(1, 0, 0);
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL fill_led got=%h exp=%h", led, 16'(m_word)); end
        n_vec++; if (carry !== 1'(m_carry)) begin n_err++; $display("FAIL fill_carry got=%b exp=%0d", carry, m_carry); end
        n_vec++; if (shift_count !== 8'(m_count)) begin n_err++; $display("FAIL fill_count got=%0d exp=%0d", shift_count, m_count); end
    endtask

    task automatic test_rotate();
        int b;
        sw_val = 16'h0001;
        press(0, 10, b);
        model_load(1);
        mode_rotate = 1'b1;
        press(2, 10, b);
        model_step(0, 1, 0);
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL rotr_led got=%h exp=%h", led, 16'(m_word)); end
        n_vec++; if (carry !== 1'(m_carry)) begin n_err++; $display("FAIL rotr_carry got=%b exp=%0d", carry, m_carry); end
        n_vec++; if (sh_dir !== 1'b0) begin n_err++; $display("FAIL rotr_dir got=%b exp=0", sh_dir); end
        press(1, 10, b);
        model_step(1, 1, 0);
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL rotl_led got=%h exp=%h", led, 16'(m_word)); end
        mode_rotate = 1'b0;
    endtask

    task automatic test_bounce();
        int b;
        @(negedge clock);
        for (int i = 0; i < 20; i++) begin
            btn_left = ~btn_left;
            repeat (2) @(negedge clock);
        end
        btn_left = 1'b0;
        repeat (14) @(negedge clock);
        n_vec++; if (shift_count !== 8'(m_count)) begin n_err++; $display("FAIL bounce_count got=%0d exp=%0d", shift_count, m_count); end
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL bounce_led got=%h exp=%h", led, 16'(m_word)); end
        press(1, 100, b);
        model_step(1, 0, int'(fill_bit));
        n_vec++; if (shift_count !== 8'(m_count)) begin n_err++; $display("FAIL hold_count got=%0d exp=%0d", shift_count, m_count); end
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL hold_led got=%h exp=%h", led, 16'(m_word)); end
    endtask

    task automatic test_random();
        int b;
        int d;
        int n;
        for (int k = 0; k < 6; k++) begin
            sw_val = 16'($urandom);
            press(0, 10, b);
            model_load(int'(sw_val));
            mode_rotate = 1'($urandom);
            fill_bit = 1'($urandom);
            n = 1 + int'($urandom_range(2));
            for (int s = 0; s < n; s++) begin
                d = int'($urandom_range(1));
                press(d ? 1 : 2, 10, b);
                model_step(d, int'(mode_rotate), int'(fill_bit));
            end
            n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL rand%0d_led got=%h exp=%h", k, led, 16'(m_word)); end
            n_vec++; if (carry !== 1'(m_carry)) begin n_err++; $display("FAIL rand%0d_carry got=%b exp=%0d", k, carry, m_carry); end
            n_vec++; if (shift_count !== 8'(m_count)) begin n_err++; $display("FAIL rand%0d_count got=%0d exp=%0d", k, shift_count, m_count); end
        end
        mode_rotate = 1'b0;
        fill_bit = 1'b0;
    endtask

    task automatic test_auto();
        int b;
        int prev;
        int waited;
        int t_last;
        int switched;
        int cr;
        int cl;
        mode_rotate = 1'b0; fill_bit = 1'b0;
        press(2, 10, b);
        model_step(0, 0, 0);
        sw_val = 16'hF000;
        press(0, 10, b);
        model_load(32'hF000);
        auto_en = 1'b1;
        t_last = 0;
        for (int s = 0; s < 3; s++) begin
            prev = int'(shift_count);
            waited = 0;
            while (int'(shift_count) == prev && waited < 40) begin
                @(negedge clock);
                waited++;
            end
            n_vec++;
            if (waited >= 40) begin
                n_err++; $display("FAIL auto_step%0d timeout got=none exp=step", s);
                break;
            end
            model_step(0, 0, 0);
            if (led !== 16'(m_word)) begin n_err++; $display("FAIL auto_step%0d_led got=%h exp=%h", s, led, 16'(m_word)); end
            if (s > 0) begin
                n_vec++;
                if (cyc - t_last != AD) begin n_err++; $display("FAIL auto_spacing got=%0d exp=%0d", cyc - t_last, AD); end
            end
            t_last = cyc;
        end
        // Left press in AUTO: steps before the pulse lands stay right, after it go left.
        switched = 0;
        btn_left = 1'b1;
        for (int c = 0; c < 40; c++) begin
            prev = int'(shift_count);
            @(negedge clock);
            if (c == 12) btn_left = 1'b0;
            if (int'(shift_count) != prev) begin
                cr = next_word(m_word, 0, 0, 0);
                cl = next_word(m_word, 1, 0, 0);
                n_vec++;
                if (switched == 0 && led === 16'(cr)) begin
                    model_step(0, 0, 0);
                end else if (led === 16'(cl)) begin
                    switched = 1;
                    model_step(1, 0, 0);
                end else begin
                    n_err++; $display("FAIL auto_dirchg_led got=%h exp=%h", led, 16'(switched ? cl : cr));
                    m_word = int'(led);
                end
            end
        end
        n_vec++; if (switched != 1) begin n_err++; $display("FAIL auto_left_taken got=%0d exp=1", switched); end
        n_vec++; if (sh_dir !== 1'b1) begin n_err++; $display("FAIL auto_dir got=%b exp=1", sh_dir); end
        // Disable: allow in-flight steps to drain, then nothing more may move.
        auto_en = 1'b0;
        for (int c = 0; c < 12; c++) begin
            prev = int'(shift_count);
            @(negedge clock);
            if (int'(shift_count) != prev) model_step(1, 0, 0);
        end
        repeat (40) @(negedge clock);
        n_vec++; if (shift_count !== 8'(m_count)) begin n_err++; $display("FAIL auto_off_count got=%0d exp=%0d", shift_count, m_count); end
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL auto_off_led got=%h exp=%h", led, 16'(m_word)); end
    endtask

    task automatic test_conflict();
        int b;
        sw_val = 16'($urandom);
        press(3, 10, b);
        model_load(int'(sw_val));
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL conflict_led got=%h exp=%h", led, 16'(m_word)); end
        n_vec++; if (shift_count !== 8'd0) begin n_err++; $display("FAIL conflict_count got=%0d exp=0", shift_count); end
        n_vec++; if (b != 1) begin n_err++; $display("FAIL conflict_busy_cycles got=%0d exp=1", b); end
        n_vec++; if (sh_dir !== 1'(m_dir)) begin n_err++; $display("FAIL conflict_dir got=%b exp=%0d", sh_dir, m_dir); end
    endtask

    task automatic test_reset_auto();
        fill_bit = 1'b1;
        auto_en = 1'b1;
        repeat (30) @(negedge clock);
        reset_n = 1'b0;
        auto_en = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        m_word = 0; m_dir = 1; m_carry = 0; m_count = 0;
        @(negedge clock);
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL rst_auto_led got=%h exp=%h", led, 16'(m_word)); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_auto_busy got=%b exp=0", busy); end
        n_vec++; if (sh_dir !== 1'b1) begin n_err++; $display("FAIL rst_auto_dir got=%b exp=1", sh_dir); end
        repeat (40) @(negedge clock);
        n_vec++; if (shift_count !== 8'(m_count)) begin n_err++; $display("FAIL rst_auto_count got=%0d exp=%0d", shift_count, m_count); end
        n_vec++; if (led !== 16'(m_word)) begin n_err++; $display("FAIL rst_auto_hold got=%h exp=%h", led, 16'(m_word)); end
        n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL rst_auto_carry got=%b exp=0", carry); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_fill();
        test_rotate();
        test_bounce();
        test_random();
        test_auto();
        test_conflict();
        test_reset_auto();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
